// File: rtl/escrita_registrador_if.sv
// Write-back stage bus: control/data inputs from the memory stage and
// register-file read ports plus debug outputs back to the datapath.
interface escrita_registrador_if #(
  parameter int unsigned CNT_W = 16
);
  logic [2:0]       estado;
  logic [31:0]      aluresult2;
  logic [31:0]      reddataM;
  logic             memtoreg;
  logic             regwrite;
  logic [2:0]       funct3;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [31:0]      dado1;
  logic [31:0]      dado2;
  logic [31:0]      wbdata;
  logic             wb_done;
  logic [CNT_W-1:0] wb_count;

  modport slave (
    input  estado, aluresult2, reddataM, memtoreg, regwrite,
           funct3, rd, rs1, rs2,
    output dado1, dado2, wbdata, wb_done, wb_count
  );

  modport master (
    output estado, aluresult2, reddataM, memtoreg, regwrite,
           funct3, rd, rs1, rs2,
    input  dado1, dado2, wbdata, wb_done, wb_count
  );
endinterface

// File: rtl/escrita_registrador.sv
// Write-back stage of the multicycle RISC-V datapath: load extension, 32x32
// register file with two async read ports. Optional macro ESCRITA_BYPASS_EN.
module escrita_registrador #(
  parameter logic [2:0]  ESTADO_WB = 3'b101,
  parameter int unsigned CNT_W     = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  escrita_registrador_if.slave bus
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREG  = 32;
  localparam int unsigned IDX_W = 5;

  logic [XLEN-1:0]  r_bank [NREG];
  logic [XLEN-1:0]  r_wbdata;
  logic             r_wb_done;
  logic [CNT_W-1:0] r_count;

  logic [XLEN-1:0]  w_ext;
  logic [XLEN-1:0]  w_result;
  logic             w_commit;
  logic             w_wr_reg;
  logic [XLEN-1:0]  w_dado1;
  logic [XLEN-1:0]  w_dado2;

  // Load-width extension; memory is word-addressed so sub-words sit in the low lane
  always_comb begin
    w_ext = bus.reddataM;
    case (bus.funct3)
      3'b000:  w_ext = {{24{bus.reddataM[7]}},  bus.reddataM[7:0]};
      3'b001:  w_ext = {{16{bus.reddataM[15]}}, bus.reddataM[15:0]};
      3'b100:  w_ext = {24'd0, bus.reddataM[7:0]};
      3'b101:  w_ext = {16'd0, bus.reddataM[15:0]};
      default: w_ext = bus.reddataM;
    endcase
  end

  assign w_result = bus.memtoreg ? w_ext : bus.aluresult2;
  assign w_commit = (bus.estado == ESTADO_WB) && bus.regwrite;
  assign w_wr_reg = w_commit && (bus.rd != IDX_W'(0));

  // Register bank; x0 is never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_bank[i] <= '0;
    end else if (w_wr_reg) begin
      r_bank[bus.rd] <= w_result;
    end
  end

  // Commit bookkeeping: last value, done pulse and wrapping retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wbdata  <= '0;
      r_wb_done <= 1'b0;
      r_count   <= '0;
    end else begin
      r_wb_done <= w_commit;
      if (w_commit) begin
        r_wbdata <= w_result;
        r_count  <= r_count + CNT_W'(1);
      end
    end
  end

  // Asynchronous read ports
  always_comb begin
    w_dado1 = (bus.rs1 == IDX_W'(0)) ? '0 : r_bank[bus.rs1];
    w_dado2 = (bus.rs2 == IDX_W'(0)) ? '0 : r_bank[bus.rs2];
`ifdef ESCRITA_BYPASS_EN
    if (w_wr_reg && (bus.rs1 == bus.rd)) w_dado1 = w_result;
    if (w_wr_reg && (bus.rs2 == bus.rd)) w_dado2 = w_result;
`endif
  end

  assign bus.dado1    = w_dado1;
  assign bus.dado2    = w_dado2;
  assign bus.wbdata   = r_wbdata;
  assign bus.wb_done  = r_wb_done;
  assign bus.wb_count = r_count;

endmodule

// File: tb/tb_escrita_registrador.sv
// Directed bench for escrita_registrador: commits, load extension, x0,
// state gating, same-cycle read, back-to-back commits and async reset.
module tb_escrita_registrador;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  int   exp_count;

  escrita_registrador_if #(.CNT_W(16)) bus ();

  escrita_registrador #(.ESTADO_WB(3'b101), .CNT_W(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [4:0] d, input logic m, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] mem);
    bus.rd         = d;
    bus.memtoreg   = m;
    bus.funct3     = f3;
    bus.aluresult2 = alu;
    bus.reddataM   = mem;
    bus.estado     = 3'b101;
    bus.regwrite   = 1'b1;
    step();
    bus.estado     = 3'b000;
    bus.regwrite   = 1'b0;
    exp_count++;
  endtask

  logic [2:0]  ld_f3  [6];
  logic [31:0] ld_exp [6];

  initial begin
    n_checks = 0; n_pass = 0; exp_count = 0;
    ld_f3[0] = 3'b000; ld_exp[0] = 32'hFFFF_FF80;
    ld_f3[1] = 3'b100; ld_exp[1] = 32'h0000_0080;
    ld_f3[2] = 3'b001; ld_exp[2] = 32'hFFFF_F680;
    ld_f3[3] = 3'b101; ld_exp[3] = 32'h0000_F680;
    ld_f3[4] = 3'b010; ld_exp[4] = 32'h1234_F680;
    ld_f3[5] = 3'b011; ld_exp[5] = 32'h1234_F680;

    rst_n = 1'b0;
    bus.estado = 3'b000; bus.aluresult2 = '0; bus.reddataM = '0;
    bus.memtoreg = 1'b0; bus.regwrite = 1'b0; bus.funct3 = 3'b000;
    bus.rd = 5'd0; bus.rs1 = 5'd5; bus.rs2 = 5'd0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    chk("rst_wbdata", bus.wbdata, 32'h0);
    chk("rst_count", 32'(bus.wb_count), 32'h0);
    chk("rst_done", 32'(bus.wb_done), 32'h0);
    chk("rst_x5", bus.dado1, 32'h0);

    // ALU commit; funct3 must be ignored when memtoreg=0
    bus.rs1 = 5'd3;
    commit(5'd3, 1'b0, 3'b000, 32'h0000_002A, 32'hFFFF_FFFF);
    chk("alu_x3", bus.dado1, 32'h0000_002A);
    chk("alu_done", 32'(bus.wb_done), 32'h1);
    chk("alu_count", 32'(bus.wb_count), 32'h1);
    step();
    chk("alu_done_clr", 32'(bus.wb_done), 32'h0);

    bus.rs1 = 5'd5;
    commit(5'd5, 1'b0, 3'b000, 32'h0000_0080, 32'h0);
    chk("alu_noext_x5", bus.dado1, 32'h0000_0080);

    bus.rs1 = 5'd4;
    for (int i = 0; i < 6; i++) begin
      commit(5'd4, 1'b1, ld_f3[i], 32'h0, 32'h1234_F680);
      chk($sformatf("load_f3_%0d_x4", ld_f3[i]), bus.dado1, ld_exp[i]);
      chk($sformatf("load_f3_%0d_wb", ld_f3[i]), bus.wbdata, ld_exp[i]);
      step();
    end
    chk("load_count", 32'(bus.wb_count), 32'(exp_count));

    // x0 protection
    bus.rs2 = 5'd0;
    commit(5'd0, 1'b0, 3'b010, 32'hDEAD_BEEF, 32'h0);
    chk("x0_read", bus.dado2, 32'h0);
    chk("x0_wbdata", bus.wbdata, 32'hDEAD_BEEF);
    chk("x0_count", 32'(bus.wb_count), 32'(exp_count));
    step();

    // State gating: estado 100 then 011 with regwrite high
    bus.rs1 = 5'd3; bus.rd = 5'd3; bus.memtoreg = 1'b0;
    bus.aluresult2 = 32'h0000_0055; bus.regwrite = 1'b1;
    bus.estado = 3'b100;
    step();
    chk("gate100_x3", bus.dado1, 32'h0000_002A);
    chk("gate100_done", 32'(bus.wb_done), 32'h0);
    chk("gate100_count", 32'(bus.wb_count), 32'(exp_count));
    bus.estado = 3'b011;
    step();
    chk("gate011_x3", bus.dado1, 32'h0000_002A);
    chk("gate011_done", 32'(bus.wb_done), 32'h0);
    chk("gate011_wbdata", bus.wbdata, 32'hDEAD_BEEF);
    bus.regwrite = 1'b0; bus.estado = 3'b000;
    step();

    // Same-cycle read of the register being written
    bus.rs1 = 5'd7;
    commit(5'd7, 1'b0, 3'b000, 32'h0000_0011, 32'h0);
    step();
    bus.rd = 5'd7; bus.memtoreg = 1'b0; bus.aluresult2 = 32'h0000_0022;
    bus.estado = 3'b101; bus.regwrite = 1'b1;
    #1;
`ifdef ESCRITA_BYPASS_EN
    chk("same_cycle_x7", bus.dado1, 32'h0000_0022);
`else
    chk("same_cycle_x7", bus.dado1, 32'h0000_0011);
`endif
    step();
    bus.estado = 3'b000; bus.regwrite = 1'b0;
    exp_count++;
    chk("after_edge_x7", bus.dado1, 32'h0000_0022);

    // Back-to-back commits keep wb_done high
    bus.rs1 = 5'd8; bus.rs2 = 5'd9;
    bus.memtoreg = 1'b0; bus.estado = 3'b101; bus.regwrite = 1'b1;
    bus.rd = 5'd8; bus.aluresult2 = 32'h0000_000A;
    step();
    chk("b2b_done1", 32'(bus.wb_done), 32'h1);
    bus.rd = 5'd9; bus.aluresult2 = 32'h0000_000B;
    step();
    chk("b2b_done2", 32'(bus.wb_done), 32'h1);
    bus.estado = 3'b000; bus.regwrite = 1'b0;
    exp_count += 2;
    chk("b2b_x8", bus.dado1, 32'h0000_000A);
    chk("b2b_x9", bus.dado2, 32'h0000_000B);
    chk("b2b_count", 32'(bus.wb_count), 32'(exp_count));

    // Reset asserted during a pending commit: clear wins, no write lands
    step();
    bus.rs1 = 5'd10; bus.rd = 5'd10; bus.aluresult2 = 32'h0000_0099;
    bus.estado = 3'b101; bus.regwrite = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wbdata_async", bus.wbdata, 32'h0);
    step();
    chk("arst_x10", bus.dado1, 32'h0);
    bus.estado = 3'b000; bus.regwrite = 1'b0;
    #3 rst_n = 1'b1;
    step();
    chk("arst_wbdata", bus.wbdata, 32'h0);
    chk("arst_count", 32'(bus.wb_count), 32'h0);
    chk("arst_done", 32'(bus.wb_done), 32'h0);
    bus.rs1 = 5'd5; bus.rs2 = 5'd3;
    #1;
    chk("arst_x5", bus.dado1, 32'h0);
    chk("arst_x3", bus.dado2, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
